// File: rtl/alu_sequencer_pkg.sv
// Shared widths, ALU function codes, status bit indices and sequencer op codes
// for the 6502 ALU sequencer, plus the per-op step program.
package alu_sequencer_pkg;

    localparam int unsigned REG_WIDTH = 8;
    localparam int unsigned OPP_WIDTH = 4;

    // ALU function codes; ALU_NOP matches no ALU operation.
    localparam logic [OPP_WIDTH-1:0] ALU_SUM = 4'd0;
    localparam logic [OPP_WIDTH-1:0] ALU_AND = 4'd1;
    localparam logic [OPP_WIDTH-1:0] ALU_OR  = 4'd2;
    localparam logic [OPP_WIDTH-1:0] ALU_XOR = 4'd3;
    localparam logic [OPP_WIDTH-1:0] ALU_SR  = 4'd4;
    localparam logic [OPP_WIDTH-1:0] ALU_NOP = 4'hF;

    // Processor status bit indices.
    localparam int unsigned CARRY      = 0;
    localparam int unsigned ZERO       = 1;
    localparam int unsigned INT_DIS    = 2;
    localparam int unsigned DEC        = 3;
    localparam int unsigned BREAK      = 4;
    localparam int unsigned V_OVERFLOW = 6;
    localparam int unsigned NEG        = 7;

    typedef enum logic [3:0] {
        SEQ_ADC = 4'd0,
        SEQ_SBC = 4'd1,
        SEQ_AND = 4'd2,
        SEQ_ORA = 4'd3,
        SEQ_EOR = 4'd4,
        SEQ_ASL = 4'd5,
        SEQ_LSR = 4'd6,
        SEQ_ROL = 4'd7,
        SEQ_ROR = 4'd8,
        SEQ_CMP = 4'd9,
        SEQ_INC = 4'd10,
        SEQ_DEC = 4'd11
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEP  = 2'd1,
        ST_EXEC = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [OPP_WIDTH-1:0] func;
        logic [REG_WIDTH-1:0] a;
        logic [REG_WIDTH-1:0] b;
        logic                 cin;
    } alu_req_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= 4'(SEQ_DEC);
    endfunction

    // ALU request for a given op/step; t is the ROR step-1 result.
    function automatic alu_req_t step_program(
        input logic [3:0]           op,
        input logic                 step,
        input logic [REG_WIDTH-1:0] a,
        input logic [REG_WIDTH-1:0] m,
        input logic [REG_WIDTH-1:0] t,
        input logic                 c
    );
        alu_req_t req;
        req = '{ALU_NOP, '0, '0, 1'b0};
        case (op)
            SEQ_ADC: req = '{ALU_SUM, a, m, c};
            SEQ_SBC: req = '{ALU_SUM, a, ~m, c};
            SEQ_AND: req = '{ALU_AND, a, m, 1'b0};
            SEQ_ORA: req = '{ALU_OR, a, m, 1'b0};
            SEQ_EOR: req = '{ALU_XOR, a, m, 1'b0};
            SEQ_ASL: req = '{ALU_SUM, m, m, 1'b0};
            SEQ_LSR: req = '{ALU_SR, m, '0, 1'b0};
            SEQ_ROL: req = '{ALU_SUM, m, m, c};
            SEQ_ROR: req = step ? '{ALU_OR, t, REG_WIDTH'(c) << (REG_WIDTH - 1), 1'b0}
                                : '{ALU_SR, m, '0, 1'b0};
            SEQ_CMP: req = '{ALU_SUM, a, ~m, 1'b1};
            SEQ_INC: req = '{ALU_SUM, m, '0, 1'b1};
            SEQ_DEC: req = '{ALU_SUM, m, '1, 1'b0};
            default: req = '{ALU_NOP, '0, '0, 1'b0};
        endcase
        return req;
    endfunction

endpackage

// File: rtl/alu_sequencer_flags.sv
// Combinational status composition: N/Z from the final result, C and V
// depending on the op, all other status bits passed through.
module alu_seq_flags
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned W = REG_WIDTH
) (
    input  logic [3:0]   op,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [W-1:0] r,
    input  logic         carry,
    input  logic [W-1:0] p_in,
    output logic [W-1:0] p_out_c
);

    always_comb begin
        p_out_c        = p_in;
        p_out_c[NEG]   = r[W-1];
        p_out_c[ZERO]  = (r == '0);
        case (op)
            SEQ_ADC, SEQ_SBC, SEQ_ASL, SEQ_LSR,
            SEQ_ROL, SEQ_ROR, SEQ_CMP: p_out_c[CARRY] = carry;
            default: ;
        endcase
        // Signed overflow from the operands actually presented to the ALU.
        if (op == SEQ_ADC || op == SEQ_SBC) begin
            p_out_c[V_OVERFLOW] = (a_msb == b_msb) && (r[W-1] != a_msb);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Initiator side of the 6502 ALU interface: issues one or two ALU steps per
// instruction with a NOP separator before each, then presents the writeback.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned W       = REG_WIDTH
) (
    input  logic                 phi1,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [W-1:0]         acc_in,
    input  logic [W-1:0]         mem_in,
    input  logic [W-1:0]         p_in,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [OPP_WIDTH-1:0] alu_func,
    output logic                 alu_carry,
    input  logic [W-1:0]         alu_dout,
    input  logic [W-1:0]         alu_status,
    input  logic                 alu_wout,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         result,
    output logic                 result_we,
    output logic [W-1:0]         p_out,
    output logic                 err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    seq_state_e state_q, state_n;

    logic [3:0]       op_q, op_n;
    logic [W-1:0]     acc_q, acc_n;
    logic [W-1:0]     mem_q, mem_n;
    logic [W-1:0]     pl_q, pl_n;
    logic [W-1:0]     t_q, t_n;
    logic             c1_q, c1_n;
    logic             step_q, step_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic [W-1:0]         alu_a_n, alu_b_n, result_n, p_out_n;
    logic [OPP_WIDTH-1:0] alu_func_n;
    logic                 alu_carry_n, busy_n, done_n, result_we_n, err_n;

    alu_req_t     req_c;
    logic         flag_carry_c;
    logic [W-1:0] flags_p_c;
    logic         unused_status_c;

    // Only the carry bit of the ALU status is consumed.
    assign unused_status_c = ^(alu_status & ~(W'(1) << CARRY));

    // ROR reports the carry shifted out in its first step.
    assign flag_carry_c = (op_q == SEQ_ROR) ? c1_q : alu_status[CARRY];

    alu_seq_flags #(.W(W)) u_flags (
        .op      (op_q),
        .a_msb   (alu_a[W-1]),
        .b_msb   (alu_b[W-1]),
        .r       (alu_dout),
        .carry   (flag_carry_c),
        .p_in    (pl_q),
        .p_out_c (flags_p_c)
    );

    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            mem_q     <= '0;
            pl_q      <= '0;
            t_q       <= '0;
            c1_q      <= 1'b0;
            step_q    <= 1'b0;
            cnt_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_func  <= ALU_NOP;
            alu_carry <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_we <= 1'b0;
            p_out     <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            acc_q     <= acc_n;
            mem_q     <= mem_n;
            pl_q      <= pl_n;
            t_q       <= t_n;
            c1_q      <= c1_n;
            step_q    <= step_n;
            cnt_q     <= cnt_n;
            alu_a     <= alu_a_n;
            alu_b     <= alu_b_n;
            alu_func  <= alu_func_n;
            alu_carry <= alu_carry_n;
            busy      <= busy_n;
            done      <= done_n;
            result    <= result_n;
            result_we <= result_we_n;
            p_out     <= p_out_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        op_n        = op_q;
        acc_n       = acc_q;
        mem_n       = mem_q;
        pl_n        = pl_q;
        t_n         = t_q;
        c1_n        = c1_q;
        step_n      = step_q;
        cnt_n       = '0;
        result_n    = result;
        p_out_n     = p_out;
        result_we_n = 1'b0;
        err_n       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_n   = op;
                    acc_n  = acc_in;
                    mem_n  = mem_in;
                    pl_n   = p_in;
                    step_n = 1'b0;
                    if (op_legal(op)) begin
                        state_n = ST_SEP;
                    end else begin
                        state_n  = ST_FIN;
                        err_n    = 1'b1;
                        result_n = '0;
                        p_out_n  = p_in;
                    end
                end
            end
            ST_SEP: state_n = ST_EXEC;
            ST_EXEC: begin
                if (alu_wout) begin
                    if (op_q == SEQ_ROR && !step_q) begin
                        state_n = ST_SEP;
                        step_n  = 1'b1;
                        t_n     = alu_dout;
                        c1_n    = alu_status[CARRY];
                    end else begin
                        state_n     = ST_FIN;
                        result_n    = alu_dout;
                        p_out_n     = flags_p_c;
                        result_we_n = (op_q != SEQ_CMP);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_n  = ST_FIN;
                    err_n    = 1'b1;
                    result_n = '0;
                    p_out_n  = pl_q;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_FIN: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // ALU drive follows the state being entered; operands hold between steps.
        req_c = step_program(op_q, step_n, acc_q, mem_q, t_q, pl_q[CARRY]);
        if (state_n == ST_EXEC) begin
            alu_func_n  = req_c.func;
            alu_a_n     = req_c.a;
            alu_b_n     = req_c.b;
            alu_carry_n = req_c.cin;
        end else begin
            alu_func_n  = ALU_NOP;
            alu_a_n     = alu_a;
            alu_b_n     = alu_b;
            alu_carry_n = alu_carry;
        end

        done_n = (state_n == ST_FIN);
        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with an ALU responder and
// an instruction-level reference model.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic                 phi1 = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [3:0]           op = '0;
    logic [7:0]           acc_in = '0, mem_in = '0, p_in = '0;
    logic [7:0]           alu_a, alu_b, alu_dout, alu_status;
    logic [OPP_WIDTH-1:0] alu_func;
    logic                 alu_carry, alu_wout;
    logic                 busy, done, result_we, err;
    logic [7:0]           result, p_out;

    int checks = 0;
    int errors = 0;
    logic stall = 1'b0;
    logic [OPP_WIDTH-1:0] last_func;
    logic [OPP_WIDTH-1:0] prev_f = ALU_NOP;

    always #5 phi1 = ~phi1;

    alu_sequencer #(.TIMEOUT(8), .W(8)) dut (
        .phi1(phi1), .reset(reset), .start(start), .op(op),
        .acc_in(acc_in), .mem_in(mem_in), .p_in(p_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_carry(alu_carry),
        .alu_dout(alu_dout), .alu_status(alu_status), .alu_wout(alu_wout),
        .busy(busy), .done(done), .result(result), .result_we(result_we),
        .p_out(p_out), .err(err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ALU responder: answers one edge after func changes to a real op.
    function automatic logic [15:0] alu_eval(input logic [3:0] f, input logic [7:0] a, b, input logic cin);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        s = '0;
        r = '0;
        c = 1'b0;
        case (f)
            ALU_SUM: begin s = {1'b0, a} + {1'b0, b} + 9'(cin); r = s[7:0]; c = s[8]; end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SR:  begin r = a >> 1; c = a[0]; end
            default: r = '0;
        endcase
        return {(8'($urandom) & 8'hFE) | {7'b0, c}, r};
    endfunction

    always @(posedge phi1 or posedge reset) begin
        if (reset) begin
            last_func  <= ALU_NOP;
            alu_wout   <= 1'b0;
            alu_dout   <= '0;
            alu_status <= '0;
        end else begin
            last_func <= alu_func;
            alu_wout  <= !stall && (alu_func != ALU_NOP) && (alu_func != last_func);
            {alu_status, alu_dout} <= alu_eval(alu_func, alu_a, alu_b, alu_carry);
        end
    end

    // Every cycle: no direct func-to-func change, NOP whenever idle.
    always @(negedge phi1) begin
        if (reset) begin
            prev_f = ALU_NOP;
        end else begin
            if (alu_func != prev_f && alu_func != ALU_NOP)
                chk("nop_separator", 32'(prev_f), 32'(ALU_NOP));
            if (!busy)
                chk("idle_func_nop", 32'(alu_func), 32'(ALU_NOP));
            prev_f = alu_func;
        end
    end

    // Instruction-level reference: expected writeback and edges from start to done.
    task automatic model(input logic [3:0] o, input logic [7:0] a, m, p, input logic st,
                         output logic [7:0] r, output logic [7:0] po,
                         output logic we, output logic er, output int lat);
        logic [8:0] s;
        logic c, v;
        c = p[0];
        v = p[6];
        r = '0;
        s = '0;
        if (o > 4'd11) begin
            r = '0; po = p; we = 1'b0; er = 1'b1; lat = 0;
            return;
        end
        if (st) begin
            r = '0; po = p; we = 1'b0; er = 1'b1; lat = 9;
            return;
        end
        case (o)
            SEQ_ADC: begin s = {1'b0, a} + {1'b0, m} + 9'(c); r = s[7:0]; c = s[8];
                           v = (a[7] == m[7]) && (r[7] != a[7]); end
            SEQ_SBC: begin s = {1'b0, a} + {1'b0, ~m} + 9'(c); r = s[7:0]; c = s[8];
                           v = (a[7] != m[7]) && (r[7] != a[7]); end
            SEQ_AND: r = a & m;
            SEQ_ORA: r = a | m;
            SEQ_EOR: r = a ^ m;
            SEQ_ASL: begin r = m << 1; c = m[7]; end
            SEQ_LSR: begin r = m >> 1; c = m[0]; end
            SEQ_ROL: begin r = {m[6:0], c}; c = m[7]; end
            SEQ_ROR: begin r = {c, m[7:1]}; c = m[0]; end
            SEQ_CMP: begin r = a - m; c = (a >= m); end
            SEQ_INC: r = m + 8'd1;
            default: r = m - 8'd1;
        endcase
        po = p;
        po[0] = c;
        po[1] = (r == 8'd0);
        po[6] = v;
        po[7] = r[7];
        we = (o != SEQ_CMP);
        er = 1'b0;
        lat = (o == SEQ_ROR) ? 6 : 3;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [7:0] a, m, p, input logic st,
                          input logic hold, output logic [7:0] gr, output logic [7:0] gp,
                          output logic gwe, output logic gerr);
        logic [7:0] er_r, er_p;
        logic       e_we, e_err, seen;
        int         lat;
        model(o, a, m, p, st, er_r, er_p, e_we, e_err, lat);
        gr = '0; gp = '0; gwe = 1'b0; gerr = 1'b0;
        @(negedge phi1);
        stall = st; start = 1'b1; op = o; acc_in = a; mem_in = m; p_in = p;
        @(posedge phi1);
        #1;
        start = hold;
        op = 4'($urandom); acc_in = 8'($urandom); mem_in = 8'($urandom); p_in = 8'($urandom);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge phi1);
            if (done) begin
                seen = 1'b1;
                start = 1'b0;
                chk("latency", 32'(k), 32'(lat));
                chk("result", 32'(result), 32'(er_r));
                chk("p_out", 32'(p_out), 32'(er_p));
                chk("result_we", 32'(result_we), 32'(e_we));
                chk("err", 32'(err), 32'(e_err));
                chk("busy_at_done", 32'(busy), 32'd1);
                gr = result; gp = p_out; gwe = result_we; gerr = err;
            end else begin
                chk("busy", 32'(busy), 32'd1);
                op = 4'($urandom); acc_in = 8'($urandom);
            end
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(negedge phi1);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_clear", 32'(busy), 32'd0);
        stall = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_we"}, 32'(result_we), 32'd0);
        chk({nm, "_err"}, 32'(err), 32'd0);
        chk({nm, "_result"}, 32'(result), 32'd0);
        chk({nm, "_p_out"}, 32'(p_out), 32'd0);
        chk({nm, "_alu_ab"}, 32'({alu_a, alu_b}), 32'd0);
        chk({nm, "_carry"}, 32'(alu_carry), 32'd0);
        chk({nm, "_func"}, 32'(alu_func), 32'(ALU_NOP));
    endtask

    initial begin
        logic [7:0] r, p;
        logic       we, e;
        logic [3:0] o;

        #1 reset = 1'b1;
        #2 chk_reset_vals("reset");
        repeat (2) @(negedge phi1);
        reset = 1'b0;

        // Hand-computed writebacks.
        run_op(SEQ_ADC, 8'h50, 8'h50, 8'h00, 1'b0, 1'b0, r, p, we, e);
        chk("adc_lit_r", 32'(r), 32'hA0); chk("adc_lit_p", 32'(p), 32'hC0); chk("adc_lit_we", 32'(we), 32'd1);
        run_op(SEQ_SBC, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0, r, p, we, e);
        chk("sbc_lit_r", 32'(r), 32'hFF); chk("sbc_lit_p", 32'(p), 32'h80);
        run_op(SEQ_ROR, 8'h33, 8'h01, 8'h01, 1'b0, 1'b0, r, p, we, e);
        chk("ror_lit_r", 32'(r), 32'h80); chk("ror_lit_p", 32'(p), 32'h81);
        run_op(SEQ_CMP, 8'h40, 8'h40, 8'h40, 1'b0, 1'b0, r, p, we, e);
        chk("cmp_lit_we", 32'(we), 32'd0); chk("cmp_lit_p", 32'(p), 32'h43);
        run_op(SEQ_AND, 8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, r, p, we, e);
        run_op(SEQ_AND, 8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, r, p, we, e);
        chk("and_lit_r", 32'(r), 32'h30);
        run_op(SEQ_ADC, 8'h12, 8'h34, 8'hA5, 1'b1, 1'b0, r, p, we, e);
        chk("timeout_lit_err", 32'(e), 32'd1); chk("timeout_lit_p", 32'(p), 32'hA5);
        run_op(4'hC, 8'h12, 8'h34, 8'h5A, 1'b0, 1'b0, r, p, we, e);
        chk("illegal_lit_err", 32'(e), 32'd1); chk("illegal_lit_p", 32'(p), 32'h5A);

        // Reset while waiting in EXEC.
        @(negedge phi1);
        stall = 1'b1; start = 1'b1; op = SEQ_ADC; acc_in = 8'h11; mem_in = 8'h22; p_in = 8'h00;
        @(posedge phi1);
        #1 start = 1'b0;
        repeat (3) @(posedge phi1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("mid_reset");
        @(negedge phi1);
        reset = 1'b0;
        stall = 1'b0;
        repeat (3) begin
            @(negedge phi1);
            chk("no_done_after_reset", 32'(done), 32'd0);
        end
        run_op(SEQ_INC, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, r, p, we, e);
        chk("inc_lit_r", 32'(r), 32'h00); chk("inc_lit_p", 32'(p), 32'h02);

        // Randomized instructions, occasional stalls, illegal ops and held start.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) o = 4'($urandom_range(12, 15));
            else                           o = 4'($urandom_range(0, 11));
            run_op(o, 8'($urandom), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, r, p, we, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
